context_switch_controller: RTL and testbench

CONTEXT_SWITCH_CONTROLLER -- requirements
Module: context_switch_controller

---
 rtl/context_switch_controller_pkg.sv | 27 ++
 rtl/context_switch_controller_rr_ctx_picker.sv | 44 ++++
 rtl/context_switch_controller.sv | 185 ++++++++++++++++++
 tb/tb_context_switch_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/context_switch_controller_pkg.sv
// -----------------------------------------------------------------------------
// context_switch_controller_pkg
// Purpose : Shared definitions for the context switch controller. Holds the
//           FSM state encoding, the trap_cause codes and a helper that derives
//           the context-index width from the context count.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package context_switch_controller_pkg;

  typedef enum logic [1:0] {
    ST_KERNEL   = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_USER     = 2'd2,
    ST_TRAP     = 2'd3
  } csc_state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_TIMER    = 2'd1;
  localparam logic [1:0] CAUSE_SYSCALL  = 2'd2;
  localparam logic [1:0] CAUSE_DISPATCH = 2'd3;

  // clog2 of the context count, never narrower than one bit.
  function automatic int ctx_width(input int num_ctx);
    return (num_ctx <= 2) ? 1 : $clog2(num_ctx);
  endfunction

endpackage

// File: rtl/context_switch_controller_rr_ctx_picker.sv
// -----------------------------------------------------------------------------
// rr_ctx_picker
// Purpose : Combinational round-robin selector over the user contexts
//           1..NUM_CTX-1. Context 0 (kernel) is never selected.
// Ports   : mask  - in  NUM_CTX  runnable mask (bit 0 ignored)
//           start - in  CTX_W    first candidate; 0 or out-of-range means 1
//           index - out CTX_W    selected context (0 when none)
//           valid - out 1        a ready user context was found
// -----------------------------------------------------------------------------
module rr_ctx_picker #(
  parameter int NUM_CTX = 8,
  parameter int CTX_W   = 3
) (
  input  logic [NUM_CTX-1:0] mask,
  input  logic [CTX_W-1:0]   start,
  output logic [CTX_W-1:0]   index,
  output logic               valid
);

  always_comb begin
    int first;
    int cand;
    index = '0;
    valid = 1'b0;
    first = 1;
    cand  = 1;
    // A start that wrapped past the last context (or landed on the kernel)
    // restarts the search at context 1.
    if ((int'(start) != 0) && (int'(start) < NUM_CTX)) begin
      first = int'(start);
    end
    for (int k = 0; k < NUM_CTX - 1; k++) begin
      cand = first + k;
      if (cand >= NUM_CTX) begin
        cand = cand - (NUM_CTX - 1);
      end
      if (!valid && mask[cand]) begin
        valid = 1'b1;
        index = CTX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/context_switch_controller.sv
// -----------------------------------------------------------------------------
// context_switch_controller
// Purpose : Kernel/user context switch sequencer. Dispatches user contexts on
//           kernel request, traps back to the kernel on syscall or quantum
//           expiry, and handshakes every PC redirect with the datapath.
// Ports   : clock         - in  1          rising-edge clock
//           reset_n       - in  1          synchronous active-low reset
//           int_enable    - in  1          enables timer countdown / expiry
//           quantum_load  - in  1          load quantum_value into quantum reg
//           quantum_value - in  QUANTUM_W  new quantum (0 disables timer)
//           ctx_ready     - in  NUM_CTX    runnable mask, bit 0 ignored
//           sys_call      - in  1          user requests kernel entry
//           change_ctx    - in  1          kernel requests dispatch
//           ctx_target    - in  CTX_W      requested user context
//           trap_ack      - in  1          datapath redirect done
//           trap_req      - out 1          redirect request
//           trap_cause    - out 2          0 none,1 timer,2 syscall,3 dispatch
//           cur_ctx       - out CTX_W      running context
//           kernel_mode   - out 1          kernel region active
//           saved_ctx     - out CTX_W      last user context that trapped
//           timer_count   - out QUANTUM_W  remaining quantum
// -----------------------------------------------------------------------------
module context_switch_controller
  import context_switch_controller_pkg::*;
#(
  parameter  int NUM_CTX         = 8,
  parameter  int QUANTUM_W       = 16,
  parameter  int DEFAULT_QUANTUM = 1000,
  localparam int CTX_W           = ctx_width(NUM_CTX)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 int_enable,
  input  logic                 quantum_load,
  input  logic [QUANTUM_W-1:0] quantum_value,
  input  logic [NUM_CTX-1:0]   ctx_ready,
  input  logic                 sys_call,
  input  logic                 change_ctx,
  input  logic [CTX_W-1:0]     ctx_target,
  input  logic                 trap_ack,
  output logic                 trap_req,
  output logic [1:0]           trap_cause,
  output logic [CTX_W-1:0]     cur_ctx,
  output logic                 kernel_mode,
  output logic [CTX_W-1:0]     saved_ctx,
  output logic [QUANTUM_W-1:0] timer_count
);

  csc_state_e           state_q, state_d;
  logic [CTX_W-1:0]     cur_ctx_q, cur_ctx_d;
  logic [CTX_W-1:0]     saved_ctx_q, saved_ctx_d;
  logic [CTX_W-1:0]     next_ctx_q, next_ctx_d;
  logic                 kernel_mode_q, kernel_mode_d;
  logic                 trap_req_q, trap_req_d;
  logic [1:0]           trap_cause_q, trap_cause_d;
  logic [QUANTUM_W-1:0] timer_q, timer_d;
  logic [QUANTUM_W-1:0] quantum_q, quantum_d;

  logic [NUM_CTX-1:0]   user_ready;
  logic [CTX_W-1:0]     rr_index;
  logic                 rr_valid;
  logic                 target_ok;
  logic [CTX_W-1:0]     sel_ctx;
  logic                 sel_valid;
  logic                 timer_dec;
  logic                 expiry;

  // The kernel is never a dispatch candidate.
  assign user_ready = {ctx_ready[NUM_CTX-1:1], 1'b0};

  // Start one past the last trapped context; the picker folds a wrapped or
  // zero start back onto context 1.
  rr_ctx_picker #(
    .NUM_CTX (NUM_CTX),
    .CTX_W   (CTX_W)
  ) u_rr_ctx_picker (
    .mask  (user_ready),
    .start (saved_ctx_q + CTX_W'(1)),
    .index (rr_index),
    .valid (rr_valid)
  );

  always_comb begin
    target_ok = 1'b0;
    if ((ctx_target != '0) && (int'(ctx_target) < NUM_CTX)) begin
      target_ok = user_ready[ctx_target];
    end
    sel_ctx   = target_ok ? ctx_target : rr_index;
    sel_valid = target_ok | rr_valid;
  end

  // Once the count reaches zero it stays there: no decrement, no expiry.
  assign timer_dec = (state_q == ST_USER) && int_enable && (timer_q != '0);
  assign expiry    = timer_dec && (timer_q == QUANTUM_W'(1));

  always_comb begin
    state_d       = state_q;
    cur_ctx_d     = cur_ctx_q;
    saved_ctx_d   = saved_ctx_q;
    next_ctx_d    = next_ctx_q;
    kernel_mode_d = kernel_mode_q;
    trap_req_d    = trap_req_q;
    trap_cause_d  = trap_cause_q;
    timer_d       = timer_q;
    // The quantum register only feeds the next reload, never the live count.
    quantum_d     = quantum_load ? quantum_value : quantum_q;

    case (state_q)
      ST_KERNEL: begin
        if (change_ctx && sel_valid) begin
          next_ctx_d   = sel_ctx;
          trap_req_d   = 1'b1;
          trap_cause_d = CAUSE_DISPATCH;
          state_d      = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (trap_ack && trap_req_q) begin
          cur_ctx_d     = next_ctx_q;
          kernel_mode_d = 1'b0;
          trap_req_d    = 1'b0;
          trap_cause_d  = CAUSE_NONE;
          timer_d       = quantum_q;
          state_d       = ST_USER;
        end
      end
      ST_USER: begin
        if (timer_dec) begin
          timer_d = timer_q - QUANTUM_W'(1);
        end
        // Syscall wins over a coincident expiry so only one trap is taken.
        if (sys_call || expiry) begin
          trap_cause_d = sys_call ? CAUSE_SYSCALL : CAUSE_TIMER;
          trap_req_d   = 1'b1;
          saved_ctx_d  = cur_ctx_q;
          state_d      = ST_TRAP;
        end
      end
      ST_TRAP: begin
        if (trap_ack && trap_req_q) begin
          cur_ctx_d     = '0;
          kernel_mode_d = 1'b1;
          trap_req_d    = 1'b0;
          trap_cause_d  = CAUSE_NONE;
          state_d       = ST_KERNEL;
        end
      end
      default: begin
        state_d = ST_KERNEL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_KERNEL;
      cur_ctx_q     <= '0;
      saved_ctx_q   <= '0;
      next_ctx_q    <= '0;
      kernel_mode_q <= 1'b1;
      trap_req_q    <= 1'b0;
      trap_cause_q  <= CAUSE_NONE;
      timer_q       <= '0;
      quantum_q     <= QUANTUM_W'(DEFAULT_QUANTUM);
    end else begin
      state_q       <= state_d;
      cur_ctx_q     <= cur_ctx_d;
      saved_ctx_q   <= saved_ctx_d;
      next_ctx_q    <= next_ctx_d;
      kernel_mode_q <= kernel_mode_d;
      trap_req_q    <= trap_req_d;
      trap_cause_q  <= trap_cause_d;
      timer_q       <= timer_d;
      quantum_q     <= quantum_d;
    end
  end

  assign trap_req    = trap_req_q;
  assign trap_cause  = trap_cause_q;
  assign cur_ctx     = cur_ctx_q;
  assign kernel_mode = kernel_mode_q;
  assign saved_ctx   = saved_ctx_q;
  assign timer_count = timer_q;

endmodule

// File: tb/tb_context_switch_controller.sv
// -----------------------------------------------------------------------------
// tb_context_switch_controller
// Purpose : Directed scoreboard bench for context_switch_controller with
//           NUM_CTX=4 and a quantum of 5. Stimulus pushes the expected
//           observable state for each trap/dispatch event; a monitor pops and
//           compares whenever trap_req rises or cur_ctx/kernel_mode change.
// -----------------------------------------------------------------------------
module tb_context_switch_controller;

  localparam int NUM_CTX   = 4;
  localparam int QUANTUM_W = 16;
  localparam int CTX_W     = 2;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 int_enable = 1'b0;
  logic                 quantum_load = 1'b0;
  logic [QUANTUM_W-1:0] quantum_value = '0;
  logic [NUM_CTX-1:0]   ctx_ready = '0;
  logic                 sys_call = 1'b0;
  logic                 change_ctx = 1'b0;
  logic [CTX_W-1:0]     ctx_target = '0;
  logic                 trap_ack = 1'b0;
  logic                 trap_req;
  logic [1:0]           trap_cause;
  logic [CTX_W-1:0]     cur_ctx;
  logic                 kernel_mode;
  logic [CTX_W-1:0]     saved_ctx;
  logic [QUANTUM_W-1:0] timer_count;

  context_switch_controller #(
    .NUM_CTX         (NUM_CTX),
    .QUANTUM_W       (QUANTUM_W),
    .DEFAULT_QUANTUM (1000)
  ) dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .int_enable    (int_enable),
    .quantum_load  (quantum_load),
    .quantum_value (quantum_value),
    .ctx_ready     (ctx_ready),
    .sys_call      (sys_call),
    .change_ctx    (change_ctx),
    .ctx_target    (ctx_target),
    .trap_ack      (trap_ack),
    .trap_req      (trap_req),
    .trap_cause    (trap_cause),
    .cur_ctx       (cur_ctx),
    .kernel_mode   (kernel_mode),
    .saved_ctx     (saved_ctx),
    .timer_count   (timer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    cause;
    int    req;
    int    cur;
    int    km;
    int    saved;
    int    timer;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic push(input string tag, input int cause, input int req, input int cur,
                      input int km, input int saved, input int timer);
    exp_t e;
    e.tag = tag; e.cause = cause; e.req = req; e.cur = cur;
    e.km = km; e.saved = saved; e.timer = timer;
    sb_q.push_back(e);
  endtask

  // Monitor: one comparison set per observable event.
  initial begin
    logic p_req;
    logic [CTX_W-1:0] p_cur;
    logic p_km;
    exp_t e;
    wait (mon_en);
    p_req = trap_req; p_cur = cur_ctx; p_km = kernel_mode;
    forever begin
      @(negedge clk);
      if ((trap_req && !p_req) || (cur_ctx != p_cur) || (kernel_mode != p_km)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: actual req=%0d cur=%0d km=%0d required no event",
                   trap_req, cur_ctx, kernel_mode);
        end else begin
          e = sb_q.pop_front();
          chk({e.tag, ".cause"}, int'(trap_cause), e.cause);
          chk({e.tag, ".trap_req"}, int'(trap_req), e.req);
          chk({e.tag, ".cur_ctx"}, int'(cur_ctx), e.cur);
          chk({e.tag, ".kernel_mode"}, int'(kernel_mode), e.km);
          chk({e.tag, ".saved_ctx"}, int'(saved_ctx), e.saved);
          chk({e.tag, ".timer"}, int'(timer_count), e.timer);
          $display("event %s: cause=%0d req=%0d cur=%0d km=%0d saved=%0d timer=%0d",
                   e.tag, trap_cause, trap_req, cur_ctx, kernel_mode, saved_ctx, timer_count);
        end
      end
      p_req = trap_req; p_cur = cur_ctx; p_km = kernel_mode;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trap_req) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s.wait_req: actual trap_req=0 required 1 within 50 cycles", tag);
  endtask

  // Called at a negedge with trap_req high; ack is sampled at the next edge.
  task automatic do_ack();
    trap_ack = 1'b1;
    @(posedge clk); #1;
    trap_ack = 1'b0;
  endtask

  task automatic pulse_change(input logic [CTX_W-1:0] tgt, input logic [NUM_CTX-1:0] rdy);
    @(posedge clk); #1;
    ctx_target = tgt; ctx_ready = rdy; change_ctx = 1'b1;
    @(posedge clk); #1;
    change_ctx = 1'b0;
  endtask

  task automatic pulse_syscall();
    @(posedge clk); #1;
    sys_call = 1'b1;
    @(posedge clk); #1;
    sys_call = 1'b0;
  endtask

  initial begin
    // Reset and initial state
    reset_n = 1'b0;
    int_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cur_ctx", int'(cur_ctx), 0);
    chk("reset.kernel_mode", int'(kernel_mode), 1);
    chk("reset.trap_req", int'(trap_req), 0);
    chk("reset.trap_cause", int'(trap_cause), 0);
    chk("reset.timer", int'(timer_count), 0);
    chk("reset.saved_ctx", int'(saved_ctx), 0);
    reset_n = 1'b1;
    quantum_value = 16'd5;
    quantum_load = 1'b1;
    @(posedge clk); #1;
    quantum_load = 1'b0;
    mon_en = 1'b1;

    // Dispatch ctx 2 by explicit target
    push("dispatch2", 3, 1, 0, 1, 0, 0);
    pulse_change(2'd2, 4'b0110);
    wait_req("dispatch2");
    push("enter2", 0, 0, 2, 0, 0, 5);
    do_ack();

    // Quantum expiry; reloads mid-run and on the expiry cycle
    push("expiry2", 1, 1, 2, 0, 2, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("expiry2.timer%0d", i), int'(timer_count), 5 - i);
      chk($sformatf("expiry2.req%0d", i), int'(trap_req), 0);
      if (i == 2) begin quantum_value = 16'd6; quantum_load = 1'b1; end
      if (i == 3) quantum_load = 1'b0;
      if (i == 4) begin quantum_value = 16'd5; quantum_load = 1'b1; end
    end
    @(posedge clk); #1;
    quantum_load = 1'b0;
    wait_req("expiry2");
    push("exit2", 0, 0, 0, 1, 2, 0);
    do_ack();

    // Dispatch ctx 3 with timer held, then syscall
    int_enable = 1'b0;
    push("dispatch3", 3, 1, 0, 1, 2, 0);
    pulse_change(2'd3, 4'b1000);
    wait_req("dispatch3");
    push("enter3", 0, 0, 3, 0, 2, 5);
    do_ack();
    repeat (3) begin
      @(negedge clk);
      chk("hold3.timer", int'(timer_count), 5);
    end
    push("syscall3", 2, 1, 3, 0, 3, 5);
    pulse_syscall();
    wait_req("syscall3");
    push("exit3", 0, 0, 0, 1, 3, 5);
    do_ack();

    // Round-robin wrap: saved=3, target=0 -> ctx 1
    push("dispatch_wrap", 3, 1, 0, 1, 3, 5);
    pulse_change(2'd0, 4'b0010);
    wait_req("dispatch_wrap");
    push("enter1", 0, 0, 1, 0, 3, 5);
    int_enable = 1'b1;
    do_ack();

    // Syscall coinciding with expiry: one trap, cause 2
    push("coincide1", 2, 1, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("coincide1.timer%0d", i), int'(timer_count), 5 - i);
      if (i == 4) sys_call = 1'b1;
    end
    @(posedge clk); #1;
    sys_call = 1'b0;
    wait_req("coincide1");
    repeat (2) begin
      @(negedge clk);
      chk("coincide1.cause_hold", int'(trap_cause), 2);
    end
    push("exit1", 0, 0, 0, 1, 1, 0);
    do_ack();

    // Target not ready: round-robin from saved+1=2 skips 2, picks 3
    push("dispatch_rr", 3, 1, 0, 1, 1, 0);
    pulse_change(2'd2, 4'b1001);
    wait_req("dispatch_rr");
    push("enter3b", 0, 0, 3, 0, 1, 5);
    int_enable = 1'b0;
    do_ack();

    // change_ctx in USER and stray trap_ack are ignored
    pulse_change(2'd1, 4'b0010);
    @(posedge clk); #1;
    trap_ack = 1'b1;
    @(posedge clk); #1;
    trap_ack = 1'b0;
    @(negedge clk);
    chk("ignored.trap_req", int'(trap_req), 0);
    chk("ignored.cur_ctx", int'(cur_ctx), 3);

    // Reset while a trap is pending
    push("syscall3b", 2, 1, 3, 0, 3, 5);
    pulse_syscall();
    wait_req("syscall3b");
    push("reset_mid", 0, 0, 0, 1, 0, 0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_mid.trap_req", int'(trap_req), 0);

    // No ready user context: change_ctx ignored
    pulse_change(2'd0, 4'b0001);
    repeat (2) begin
      @(negedge clk);
      chk("noready.trap_req", int'(trap_req), 0);
      chk("noready.kernel_mode", int'(kernel_mode), 1);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
